queue_event_ctrl: RTL and testbench
===================================

Name: queue_event_ctrl

Overview:
- Upstream front end of the bank-queue people counter.
- Takes two raw, bouncy, asynchronous sensor inputs: entry photocell (customer joins the queue) and teller "next customer" button (customer leaves the queue).
- Synchronises and debounces both, detects rising edges, and arbitrates against the queue full/empty flags.
- Emits single-cycle count strobes with an up/down direction for the queue counter, plus rejection pulses and a served-customer tally for the display path.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a sensor must hold a new level before it is accepted. Legal range 2..255.
- SERVED_W, 8: width of the saturating served-customer counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- enter_raw  in  1  raw entry sensor, asynchronous, active-high
- leave_raw  in  1  raw teller-call button, asynchronous, active-high
- full  in  1  queue-full flag from the flags stage
- empty  in  1  queue-empty flag from the flags stage
- cnt_en  out  1  one-cycle strobe: counter steps this cycle
- updown  out  1  direction qualifying cnt_en: 1 = up (enter), 0 = down (leave)
- rej_full  out  1  one-cycle pulse: accepted entry dropped because full=1
- rej_empty  out  1  one-cycle pulse: accepted leave dropped because empty=1
- served  out  SERVED_W  count of issued down-steps, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - Synchronisers, debounced levels and debounce counters go to 0.
  - Reset wins over everything, mid-debounce included. A pending event is discarded.
- Synchronisation: two-flop synchronizer per raw input. Only the second-stage value is used.
- Debounce, per channel:
  - Counter runs while the synchronised value differs from the debounced level. It clears whenever they match.
  - When the counter has seen DEBOUNCE_CYCLES consecutive differing cycles, the debounced level takes the new value.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- Event: rising edge of a debounced level. Falling edges generate nothing.
- Latency: for a clean raw 0→1 held high, the strobe is registered and asserts exactly DEBOUNCE_CYCLES+3 rising clk edges after the first edge that samples raw high. It is high for exactly one cycle.
- Arbitration, evaluated in the cycle both event signals are known, with full/empty sampled that same cycle:
  - Enter only, full=0: cnt_en=1, updown=1.
  - Enter only, full=1: rej_full=1, cnt_en=0.
  - Leave only, empty=0: cnt_en=1, updown=0, served increments.
  - Leave only, empty=1: rej_empty=1, cnt_en=0.
  - Both, with full=0 and empty=0: net zero. cnt_en=0, served increments, no reject.
  - Both, with empty=1: enter issued (cnt_en=1, updown=1); leave rejected (rej_empty=1).
  - Both, with full=1: leave issued (cnt_en=1, updown=0, served increments); enter rejected (rej_full=1).
  - full=1 and empty=1 together is illegal. Leave wins the decision and rej_full pulses.
- updown holds its last value when cnt_en=0. It resets to 0.
- served saturates at 2^SERVED_W−1 and never wraps.
- Sensor held high across reset release: the debounced level starts at 0, so exactly one event is generated after the standard latency.
- Only one event per channel per debounce window. Re-triggering requires the debounced level to return to 0 first.

Decomposition:
- Shared package holds:
  - default DEBOUNCE_CYCLES
  - SERVED_W
  - the direction encoding constants DIR_UP=1 and DIR_DOWN=0, shared with the up/down counter
- One sub-module, sensor_debounce: synchronizer, debounce counter, debounced level and rising-edge pulse. Instantiated twice.
- Arbitration and the served counter live in the top.

Test Plan:
- Reset, then enter_raw high for 20 cycles, full=0 → one cnt_en pulse with updown=1 at edge DEBOUNCE_CYCLES+3 (7 with defaults); no further pulses; served=0.
- leave_raw glitch of 2 cycles, then 0 → no cnt_en and no rej_empty; debounced level stays 0.
- leave_raw clean press, empty=0, repeated 3 times with release between → three cnt_en pulses with updown=0; served=3.
- enter press with full=1 → rej_full pulse only, cnt_en=0; leave press with empty=1 → rej_empty pulse only.
- Both raw inputs rise on the same edge, full=0, empty=0 → no cnt_en, served increments by 1. Repeat with empty=1 → cnt_en with updown=1 plus rej_empty on the same cycle.
- reset asserted 3 cycles into a debounce window → all outputs 0 immediately. After release with enter_raw still high → exactly one up pulse 7 edges later. Separately, force 256 leaves → served holds at 255.

Source files
------------

// File: rtl/queue_event_ctrl_pkg.sv
// Shared constants and types for the bank-queue event front end.
// The direction encoding is also used by the downstream up/down counter.
package queue_event_ctrl_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned SERVED_W_DEF        = 8;
    localparam int unsigned DB_CNT_W            = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Decision for one cycle of enter/leave events against the queue flags
    typedef struct packed {
        logic step;
        logic dir;
        logic rej_full;
        logic rej_empty;
        logic served_inc;
    } arb_t;

endpackage

// File: rtl/queue_event_ctrl_debounce.sv
// One sensor channel: two-flop synchroniser, debounce counter, debounced level
// and a registered single-cycle pulse on each rising edge of that level.
module sensor_debounce
    import queue_event_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic rise_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync2_q;
    logic                level_q, level_d;
    logic                prev_q;
    logic                rise_q;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised value disagrees with the level
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            // Edge detect on the registered level keeps the strobe latency fixed
            prev_q  <= level_q;
            rise_q  <= level_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/queue_event_ctrl.sv
// Queue front end: debounces the entry sensor and teller button, arbitrates
// their events against full/empty and drives counter strobes and a served tally.
module queue_event_ctrl
    import queue_event_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SERVED_W        = SERVED_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enter_raw,
    input  logic                leave_raw,
    input  logic                full,
    input  logic                empty,
    output logic                cnt_en,
    output logic                updown,
    output logic                rej_full,
    output logic                rej_empty,
    output logic [SERVED_W-1:0] served
);

    logic                enter_ev, leave_ev;
    arb_t                arb;
    logic                cnt_en_q, rej_full_q, rej_empty_q;
    logic                updown_q, updown_d;
    logic [SERVED_W-1:0] served_q, served_d;

    function automatic logic [SERVED_W-1:0] sat_inc(input logic [SERVED_W-1:0] v);
        return (&v) ? v : v + SERVED_W'(1);
    endfunction

    // Simultaneous events cancel unless a flag blocks one side; full+empty lets leave win
    function automatic arb_t arbitrate(input logic ent, input logic lev,
                                       input logic is_full, input logic is_empty);
        arb_t r;
        r     = '0;
        r.dir = DIR_DOWN;
        if (ent && lev) begin
            if (is_full) begin
                r.step       = 1'b1;
                r.dir        = DIR_DOWN;
                r.served_inc = 1'b1;
                r.rej_full   = 1'b1;
            end else if (is_empty) begin
                r.step      = 1'b1;
                r.dir       = DIR_UP;
                r.rej_empty = 1'b1;
            end else begin
                r.served_inc = 1'b1;
            end
        end else if (ent) begin
            if (is_full) begin
                r.rej_full = 1'b1;
            end else begin
                r.step = 1'b1;
                r.dir  = DIR_UP;
            end
        end else if (lev) begin
            if (is_empty) begin
                r.rej_empty = 1'b1;
            end else begin
                r.step       = 1'b1;
                r.dir        = DIR_DOWN;
                r.served_inc = 1'b1;
            end
        end
        return r;
    endfunction

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk_i  (clk),
        .rst_ni (reset),
        .raw_i  (enter_raw),
        .rise_o (enter_ev)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_leave (
        .clk_i  (clk),
        .rst_ni (reset),
        .raw_i  (leave_raw),
        .rise_o (leave_ev)
    );

    always_comb begin
        arb      = arbitrate(enter_ev, leave_ev, full, empty);
        updown_d = arb.step ? arb.dir : updown_q;
        served_d = arb.served_inc ? sat_inc(served_q) : served_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_en_q    <= 1'b0;
            updown_q    <= 1'b0;
            rej_full_q  <= 1'b0;
            rej_empty_q <= 1'b0;
            served_q    <= '0;
        end else begin
            cnt_en_q    <= arb.step;
            updown_q    <= updown_d;
            rej_full_q  <= arb.rej_full;
            rej_empty_q <= arb.rej_empty;
            served_q    <= served_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign updown    = updown_q;
    assign rej_full  = rej_full_q;
    assign rej_empty = rej_empty_q;
    assign served    = served_q;

endmodule

// File: tb/tb_queue_event_ctrl.sv
// Bench for queue_event_ctrl: directed sensor presses, a window-based model of
// the debounce/arbitration rules checked every cycle, plus literal expectations.
module tb_queue_event_ctrl;

    localparam int N    = 4;
    localparam int SW   = 8;
    localparam int MAXE = 8192;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enter_raw = 1'b0;
    logic          leave_raw = 1'b0;
    logic          full = 1'b0;
    logic          empty = 1'b0;
    logic          cnt_en, updown, rej_full, rej_empty;
    logic [SW-1:0] served;

    int n_pass = 0;
    int n_checks = 0;

    queue_event_ctrl #(.DEBOUNCE_CYCLES(N), .SERVED_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enter_raw (enter_raw),
        .leave_raw (leave_raw),
        .full      (full),
        .empty     (empty),
        .cnt_en    (cnt_en),
        .updown    (updown),
        .rej_full  (rej_full),
        .rej_empty (rej_empty),
        .served    (served)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Channel 0 = enter, 1 = leave. hist holds raw samples taken at each edge
    // since reset release; samples before release count as 0.
    bit hist [2][MAXE];
    bit ev   [2][MAXE];
    bit lvl  [2];
    int chg  [2];
    int t;
    bit m_cnt_en = 0, m_updown = 0, m_rej_full = 0, m_rej_empty = 0;
    int m_served = 0;

    function automatic bit raw_at(input int ch, input int k);
        if (k < 0) return 1'b0;
        return hist[ch][k];
    endfunction

    // Level flips at edge te when the last N synchronised samples (raw delayed
    // by two edges) all disagree with it and all arrived after its last flip.
    function automatic bit level_flips(input int ch, input int te);
        if (te - chg[ch] < N) return 1'b0;
        for (int j = 2; j <= N + 1; j++)
            if (raw_at(ch, te - j) == lvl[ch]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        t = 0;
        lvl[0] = 0; lvl[1] = 0;
        chg[0] = -1000; chg[1] = -1000;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                t = 0;
                lvl[0] = 0; lvl[1] = 0;
                chg[0] = -1000; chg[1] = -1000;
                m_cnt_en = 0; m_updown = 0; m_rej_full = 0; m_rej_empty = 0;
                m_served = 0;
            end else if (t < MAXE) begin
                bit e, l, inc;
                hist[0][t] = enter_raw;
                hist[1][t] = leave_raw;
                for (int ch = 0; ch < 2; ch++) begin
                    ev[ch][t] = 1'b0;
                    if (level_flips(ch, t)) begin
                        lvl[ch] = !lvl[ch];
                        chg[ch] = t;
                        ev[ch][t] = lvl[ch];
                    end
                end
                // A level rise at edge te shows on the outputs after edge te+2
                e = (t >= 2) ? ev[0][t-2] : 1'b0;
                l = (t >= 2) ? ev[1][t-2] : 1'b0;
                m_cnt_en = 0; m_rej_full = 0; m_rej_empty = 0; inc = 0;
                if (e && l) begin
                    if (full) begin
                        m_cnt_en = 1; m_updown = 0; inc = 1; m_rej_full = 1;
                    end else if (empty) begin
                        m_cnt_en = 1; m_updown = 1; m_rej_empty = 1;
                    end else begin
                        inc = 1;
                    end
                end else if (e) begin
                    if (full) m_rej_full = 1;
                    else begin m_cnt_en = 1; m_updown = 1; end
                end else if (l) begin
                    if (empty) m_rej_empty = 1;
                    else begin m_cnt_en = 1; m_updown = 0; inc = 1; end
                end
                if (inc && m_served < (1 << SW) - 1) m_served++;
                t++;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("cnt_en", int'(cnt_en), int'(m_cnt_en));
            check("updown", int'(updown), int'(m_updown));
            check("rej_full", int'(rej_full), int'(m_rej_full));
            check("rej_empty", int'(rej_empty), int'(m_rej_empty));
            check("served", int'(served), m_served);
        end
    end

    // ---------------- stimulus ----------------
    int p_cnt, p_up, p_dn, p_rf, p_re, p_coin, p_first;

    // Drive both raw inputs high for hi edges then low for lo edges, tallying
    // output pulses; p_first is the edge index (0 = first sampling edge).
    task automatic press(input bit ent, input bit lev, input int hi, input int lo,
                         input bit release_rst);
        p_cnt = 0; p_up = 0; p_dn = 0; p_rf = 0; p_re = 0; p_coin = 0; p_first = -1;
        @(negedge clk);
        enter_raw = ent;
        leave_raw = lev;
        if (release_rst) reset = 1'b1;
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) begin
                @(negedge clk);
                enter_raw = 1'b0;
                leave_raw = 1'b0;
            end
            @(posedge clk);
            #1;
            if (cnt_en) begin
                p_cnt++;
                if (updown) p_up++; else p_dn++;
            end
            if (rej_full) p_rf++;
            if (rej_empty) p_re++;
            if (cnt_en && rej_empty) p_coin++;
            if (p_first < 0 && (cnt_en || rej_full || rej_empty)) p_first = i;
        end
    endtask

    initial begin
        int total_dn;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cnt_en", int'(cnt_en), 0);
        check("reset_served", int'(served), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Clean entry press, held 20 cycles
        press(1, 0, 20, 10, 0);
        check("enter_latency", p_first, 7);
        check("enter_pulses", p_cnt, 1);
        check("enter_up", p_up, 1);
        check("enter_served", int'(served), 0);

        // Two-cycle glitch on the teller button
        press(0, 1, 2, 15, 0);
        check("glitch_cnt", p_cnt, 0);
        check("glitch_rej", p_re, 0);

        // Three clean leaves
        total_dn = 0;
        for (int k = 0; k < 3; k++) begin
            press(0, 1, 10, 10, 0);
            total_dn += p_dn;
        end
        check("leave_pulses", total_dn, 3);
        check("leave_served", int'(served), 3);

        // Rejections
        full = 1'b1;
        press(1, 0, 10, 10, 0);
        check("full_rej", p_rf, 1);
        check("full_cnt", p_cnt, 0);
        full = 1'b0;
        empty = 1'b1;
        press(0, 1, 10, 10, 0);
        check("empty_rej", p_re, 1);
        check("empty_cnt", p_cnt, 0);
        empty = 1'b0;

        // Simultaneous events
        press(1, 1, 10, 10, 0);
        check("both_cnt", p_cnt, 0);
        check("both_served", int'(served), 4);
        empty = 1'b1;
        press(1, 1, 10, 10, 0);
        check("both_empty_up", p_up, 1);
        check("both_empty_coin", p_coin, 1);
        empty = 1'b0;
        full = 1'b1;
        press(1, 1, 10, 10, 0);
        check("both_full_dn", p_dn, 1);
        check("both_full_rej", p_rf, 1);
        empty = 1'b1;
        press(1, 1, 10, 10, 0);
        check("both_illegal_dn", p_dn, 1);
        check("both_illegal_rej", p_rf, 1);
        check("both_illegal_served", int'(served), 6);
        full = 1'b0;
        empty = 1'b0;

        // Asynchronous reset three cycles into an entry debounce window
        @(negedge clk);
        enter_raw = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_served", int'(served), 0);
        check("mid_rst_cnt_en", int'(cnt_en), 0);
        check("mid_rst_updown", int'(updown), 0);
        repeat (2) @(posedge clk);
        press(1, 0, 20, 10, 1);
        check("post_rst_latency", p_first, 7);
        check("post_rst_pulses", p_cnt, 1);

        // Saturation of the served tally
        for (int k = 0; k < 256; k++) press(0, 1, 6, 8, 0);
        check("served_sat", int'(served), 255);
        press(0, 1, 6, 8, 0);
        check("served_hold", int'(served), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
